ntt_agu: RTL and testbench



---
 rtl/ntt_agu.sv | 177 +++++++++++++++++
 tb/tb_ntt_agu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_agu.sv
// rtl/ntt_agu.sv - NTT/INTT/pointwise address generator and butterfly sequencer
module ntt_agu #(
    parameter int LOGN    = 8,
    parameter int RD_LAT  = 1,
    parameter int BFU_LAT = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      mode_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            rd_en_o,
    output logic [LOGN-1:0] rd_addr_a_o,
    output logic [LOGN-1:0] rd_addr_b_o,
    output logic [LOGN-1:0] tw_addr_o,
    output logic            bfu_vld_o,
    output logic [1:0]      bfu_op_o,
    output logic            wr_en_o,
    output logic [LOGN-1:0] wr_addr_a_o,
    output logic [LOGN-1:0] wr_addr_b_o
);
    localparam int D  = RD_LAT + BFU_LAT;
    localparam int DW = $clog2(D + 1);
    localparam logic [LOGN-1:0] ONE  = {{(LOGN-1){1'b0}}, 1'b1};
    localparam logic [LOGN-1:0] HALF = {1'b1, {(LOGN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [LOGN-1:0] j_q, j_d;
    logic [3:0]      s_q, s_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;

    logic            pw, last_j, last_s;
    logic [4:0]      s5, sp1;
    logic [LOGN-1:0] h, g, k, a, b, tw;

    logic            vld_sr_q [RD_LAT];
    logic [1:0]      op_sr_q  [RD_LAT];
    logic            wen_sr_q [D];
    logic [LOGN-1:0] wa_sr_q  [D];
    logic [LOGN-1:0] wb_sr_q  [D];

    assign pw     = (mode_q == 2'b10);
    assign last_j = pw ? (j_q == {LOGN{1'b1}}) : (j_q == HALF - ONE);
    assign last_s = pw || (s_q == 4'(LOGN - 1));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        j_d     = j_q;
        s_d     = s_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            IDLE: begin
                if (start_i && mode_i != 2'b11) begin
                    state_d = ISSUE;
                    mode_d  = mode_i;
                    j_d     = '0;
                    s_d     = '0;
                end
            end
            ISSUE: begin
                j_d = j_q + ONE;
                if (last_j) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + DW'(1);
                if (dcnt_q == DW'(D - 1)) begin
                    if (last_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        j_d     = '0;
                        s_d     = s_q + 4'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Butterfly pair (a, b = a + h) and twiddle index for the current j and stage
    always_comb begin
        s5  = {1'b0, s_q};
        sp1 = s5 + 5'd1;
        h   = '0;
        g   = '0;
        k   = '0;
        a   = '0;
        b   = '0;
        tw  = '0;
        if (state_q == ISSUE) begin
            case (mode_q)
                2'b00: begin
                    h  = HALF >> s5;
                    g  = j_q >> (5'(LOGN - 1) - s5);
                    k  = j_q & (h - ONE);
                    a  = (g << (5'(LOGN) - s5)) + k;
                    b  = a + h;
                    tw = (ONE << s5) + g;
                end
                2'b01: begin
                    h  = ONE << s5;
                    g  = j_q >> s5;
                    k  = j_q & (h - ONE);
                    a  = (g << sp1) + k;
                    b  = a + h;
                    tw = HALF >> s5;
                    tw = tw + g;
                end
                default: begin
                    a = j_q;
                    b = j_q;
                end
            endcase
        end
    end

    assign rd_en_o     = (state_q == ISSUE);
    assign busy_o      = (state_q == ISSUE) || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);
    assign rd_addr_a_o = a;
    assign rd_addr_b_o = b;
    assign tw_addr_o   = tw;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            j_q     <= '0;
            s_q     <= '0;
            dcnt_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                vld_sr_q[i] <= 1'b0;
                op_sr_q[i]  <= 2'b00;
            end
            for (int i = 0; i < D; i++) begin
                wen_sr_q[i] <= 1'b0;
                wa_sr_q[i]  <= '0;
                wb_sr_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            j_q     <= j_d;
            s_q     <= s_d;
            dcnt_q  <= dcnt_d;
            vld_sr_q[0] <= rd_en_o;
            op_sr_q[0]  <= rd_en_o ? mode_q : 2'b00;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr_q[i] <= vld_sr_q[i-1];
                op_sr_q[i]  <= op_sr_q[i-1];
            end
            wen_sr_q[0] <= rd_en_o;
            wa_sr_q[0]  <= a;
            wb_sr_q[0]  <= b;
            for (int i = 1; i < D; i++) begin
                wen_sr_q[i] <= wen_sr_q[i-1];
                wa_sr_q[i]  <= wa_sr_q[i-1];
                wb_sr_q[i]  <= wb_sr_q[i-1];
            end
        end
    end

    assign bfu_vld_o   = vld_sr_q[RD_LAT-1];
    assign bfu_op_o    = vld_sr_q[RD_LAT-1] ? op_sr_q[RD_LAT-1] : 2'b00;
    assign wr_en_o     = wen_sr_q[D-1];
    assign wr_addr_a_o = wa_sr_q[D-1];
    assign wr_addr_b_o = wb_sr_q[D-1];
endmodule

// File: tb/tb_ntt_agu.sv
// tb/tb_ntt_agu.sv - scoreboard bench for ntt_agu against a loop-nest reference model
module tb_ntt_agu;
    localparam int LOGN    = 3;
    localparam int RD_LAT  = 1;
    localparam int BFU_LAT = 8;
    localparam int D       = RD_LAT + BFU_LAT;
    localparam int N       = 1 << LOGN;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic            busy_o, done_o, rd_en_o, bfu_vld_o, wr_en_o;
    logic [LOGN-1:0] rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o;
    logic [1:0]      bfu_op_o;

    ntt_agu #(.LOGN(LOGN), .RD_LAT(RD_LAT), .BFU_LAT(BFU_LAT)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
        .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
        .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .tw_addr_o(tw_addr_o),
        .bfu_vld_o(bfu_vld_o), .bfu_op_o(bfu_op_o), .wr_en_o(wr_en_o),
        .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int a; int b; int tw;} ev_t;
    ev_t rd_q[$];
    ev_t bfu_q[$];
    ev_t wr_q[$];
    int  done_q[$];

    int checks = 0, errors = 0;
    int busy_lo = 1, busy_hi = 0;
    int exp_done_cyc = 0;
    int zero_chk_cyc = -1, end_cyc = -1;
    bit mon_en = 1'b0;

    // Loop nest of the transform: stage s, butterfly j -> pair, twiddle, issue cycle
    task automatic model_run(input int c0, input logic [1:0] m);
        int S, M, c, h, g, k, a, b, tw;
        S = (m == 2'b10) ? 1 : LOGN;
        M = (m == 2'b10) ? N : N / 2;
        for (int s = 0; s < S; s++) begin
            for (int j = 0; j < M; j++) begin
                c = c0 + 1 + s * (M + D) + j;
                if (m == 2'b00) begin
                    h = N / (2 ** (s + 1)); g = j / h; k = j % h;
                    a = 2 * g * h + k; b = a + h; tw = (2 ** s) + g;
                end else if (m == 2'b01) begin
                    h = 2 ** s; g = j / h; k = j % h;
                    a = 2 * g * h + k; b = a + h; tw = N / (2 ** (s + 1)) + g;
                end else begin
                    a = j; b = j; tw = 0;
                end
                rd_q.push_back('{c, a, b, tw});
                bfu_q.push_back('{c + RD_LAT, int'(m), 0, 0});
                wr_q.push_back('{c + D, a, b, 0});
            end
        end
        exp_done_cyc = c0 + 1 + S * (M + D);
        done_q.push_back(exp_done_cyc);
        busy_lo = c0 + 1;
        busy_hi = exp_done_cyc - 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        if (m != 2'b11 && cyc > exp_done_cyc) model_run(cyc, m);
        tick();
        start = 1'b0;
        mode  = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_idle();
        while (cyc <= exp_done_cyc) tick();
    endtask

    always @(negedge clk) begin
        ev_t e;
        bit  exp_b;
        if (mon_en) begin
            exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
            checks++;
            if (busy_o !== exp_b) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%0b want=%0b", cyc, busy_o, exp_b);
            end
            if (rd_en_o) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected cyc=%0d a=%0d b=%0d", cyc, rd_addr_a_o, rd_addr_b_o);
                end else begin
                    e = rd_q.pop_front();
                    if (e.cyc != cyc || e.a != int'(rd_addr_a_o) || e.b != int'(rd_addr_b_o) || e.tw != int'(tw_addr_o)) begin
                        errors++;
                        $display("FAIL rd got cyc=%0d a=%0d b=%0d tw=%0d want cyc=%0d a=%0d b=%0d tw=%0d",
                                 cyc, rd_addr_a_o, rd_addr_b_o, tw_addr_o, e.cyc, e.a, e.b, e.tw);
                    end
                end
            end
            if (bfu_vld_o) begin
                checks++;
                if (bfu_q.size() == 0) begin
                    errors++;
                    $display("FAIL bfu_unexpected cyc=%0d op=%0d", cyc, bfu_op_o);
                end else begin
                    e = bfu_q.pop_front();
                    if (e.cyc != cyc || e.a != int'(bfu_op_o)) begin
                        errors++;
                        $display("FAIL bfu got cyc=%0d op=%0d want cyc=%0d op=%0d", cyc, bfu_op_o, e.cyc, e.a);
                    end
                end
            end
            if (wr_en_o) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected cyc=%0d a=%0d b=%0d", cyc, wr_addr_a_o, wr_addr_b_o);
                end else begin
                    e = wr_q.pop_front();
                    if (e.cyc != cyc || e.a != int'(wr_addr_a_o) || e.b != int'(wr_addr_b_o)) begin
                        errors++;
                        $display("FAIL wr got cyc=%0d a=%0d b=%0d want cyc=%0d a=%0d b=%0d",
                                 cyc, wr_addr_a_o, wr_addr_b_o, e.cyc, e.a, e.b);
                    end
                end
            end
            if (done_o) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d", cyc);
                end else if (done_q[0] != cyc) begin
                    errors++;
                    $display("FAIL done got cyc=%0d want cyc=%0d", cyc, done_q[0]);
                    void'(done_q.pop_front());
                end else begin
                    void'(done_q.pop_front());
                end
            end
            if (cyc == zero_chk_cyc) begin
                checks++;
                if ({busy_o, done_o, rd_en_o, bfu_vld_o, wr_en_o, bfu_op_o} !== '0 ||
                    {rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o} !== '0) begin
                    errors++;
                    $display("FAIL reset_zero cyc=%0d busy=%0b done=%0b rd=%0b vld=%0b wr=%0b op=%0d a=%0d b=%0d tw=%0d wa=%0d wb=%0d want all 0",
                             cyc, busy_o, done_o, rd_en_o, bfu_vld_o, wr_en_o, bfu_op_o,
                             rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o);
                end
            end
            if (cyc == end_cyc) begin
                checks++;
                if (rd_q.size() + bfu_q.size() + wr_q.size() + done_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover rd=%0d bfu=%0d wr=%0d done=%0d want 0",
                             rd_q.size(), bfu_q.size(), wr_q.size(), done_q.size());
                end
            end
        end
    end

    initial begin
        int t;
        rst = 1'b1;
        repeat (3) tick();
        rst          = 1'b0;
        exp_done_cyc = cyc - 1;
        zero_chk_cyc = cyc;
        mon_en       = 1'b1;
        repeat (2) tick();

        // NTT with stray start mid-run, start on done (ignored), start right after (INTT)
        t = cyc;
        pulse(2'b00);
        tick_to(t + 20);
        pulse(2'b01);
        tick_to(t + 40);
        pulse(2'b00);
        pulse(2'b01);
        wait_idle();
        repeat (2) tick();

        pulse(2'b10);
        wait_idle();
        pulse(2'b11);
        repeat (6) tick();

        // Reset in the middle of the second NTT stage
        t = cyc;
        pulse(2'b00);
        tick_to(t + 16);
        rst     = 1'b1;
        busy_hi = t + 16;
        tick();
        rst = 1'b0;
        rd_q.delete();
        bfu_q.delete();
        wr_q.delete();
        done_q.delete();
        exp_done_cyc = t + 16;
        zero_chk_cyc = cyc;
        tick_to(t + 20);
        pulse(2'b00);
        wait_idle();

        repeat (25) begin
            repeat ($urandom_range(0, 50)) tick();
            pulse(2'($urandom_range(0, 3)));
        end
        wait_idle();
        repeat (D + 3) tick();
        end_cyc = cyc;
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
